// File: rtl/decode_stage.sv
// Decode/operand-fetch stage and D/X pipeline register: regfile read addressing, writeback bypass,
// load-use hazard detection (one-cycle stall plus bubble). Latency one cycle F/D->D/X; stall is combinational.
module decode_stage #(
    parameter int              WIDTH = 32,
    parameter int              AW    = 5,
    parameter logic [WIDTH-1:0] NOP  = 32'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] fd_instruction,
    input  logic [WIDTH-1:0] fd_PC,
    input  logic             flush,
    output logic [AW-1:0]    ctrl_readRegA,
    output logic [AW-1:0]    ctrl_readRegB,
    input  logic [WIDTH-1:0] data_readRegA,
    input  logic [WIDTH-1:0] data_readRegB,
    input  logic             wb_writeEnable,
    input  logic [AW-1:0]    wb_ctrl_writeReg,
    input  logic [WIDTH-1:0] wb_result,
    output logic             stall,
    output logic [WIDTH-1:0] dx_instruction,
    output logic [WIDTH-1:0] dx_PC,
    output logic [WIDTH-1:0] dx_A,
    output logic [WIDTH-1:0] dx_B
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [AW-1:0] REG_STATUS = AW'(30);

    logic [4:0]    fd_op;
    logic [AW-1:0] fd_rd, fd_rs, fd_rt;
    logic [4:0]    dx_op;
    logic [AW-1:0] dx_rd;

    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic          a_used, b_used;
    logic [WIDTH-1:0] opnd_a, opnd_b;
    logic          hazard;

    logic [WIDTH-1:0] dx_instruction_q, dx_instruction_d;
    logic [WIDTH-1:0] dx_pc_q, dx_pc_d;
    logic [WIDTH-1:0] dx_a_q, dx_a_d;
    logic [WIDTH-1:0] dx_b_q, dx_b_d;

    assign fd_op = fd_instruction[31:27];
    assign fd_rd = fd_instruction[26:22];
    assign fd_rs = fd_instruction[21:17];
    assign fd_rt = fd_instruction[16:12];
    assign dx_op = dx_instruction_q[31:27];
    assign dx_rd = dx_instruction_q[26:22];

    // Source-slot mapping; a B slot tied to r0 is treated as unused for hazard purposes.
    always_comb begin
        rd_addr_a = fd_rs;
        rd_addr_b = '0;
        a_used    = 1'b1;
        b_used    = 1'b0;
        case (fd_op)
            OP_RTYPE: begin
                rd_addr_b = fd_rt;
                b_used    = 1'b1;
            end
            OP_SW: begin
                rd_addr_b = fd_rd;
                b_used    = 1'b1;
            end
            OP_BNE, OP_BLT: begin
                rd_addr_a = fd_rd;
                rd_addr_b = fd_rs;
                b_used    = 1'b1;
            end
            OP_JR:   rd_addr_a = fd_rd;
            OP_BEX:  rd_addr_a = REG_STATUS;
            default: ;
        endcase
    end

    assign ctrl_readRegA = rd_addr_a;
    assign ctrl_readRegB = rd_addr_b;

    // r0 reads as zero even if writeback targets it or the regfile returns junk.
    always_comb begin
        opnd_a = data_readRegA;
        if (rd_addr_a == '0)
            opnd_a = '0;
        else if (wb_writeEnable && (wb_ctrl_writeReg == rd_addr_a))
            opnd_a = wb_result;
    end

    always_comb begin
        opnd_b = data_readRegB;
        if (rd_addr_b == '0)
            opnd_b = '0;
        else if (wb_writeEnable && (wb_ctrl_writeReg == rd_addr_b))
            opnd_b = wb_result;
    end

    always_comb begin
        hazard = 1'b0;
        if ((dx_op == OP_LW) && (dx_rd != '0)) begin
            if (a_used && (rd_addr_a == dx_rd))
                hazard = 1'b1;
            if (b_used && (rd_addr_b == dx_rd))
                hazard = 1'b1;
        end
    end

    assign stall = hazard && !flush;

    always_comb begin
        dx_instruction_d = fd_instruction;
        dx_pc_d          = fd_PC;
        dx_a_d           = opnd_a;
        dx_b_d           = opnd_b;
        if (reset || flush) begin
            dx_instruction_d = NOP;
            dx_pc_d          = '0;
            dx_a_d           = '0;
            dx_b_d           = '0;
        end else if (stall) begin
            // Bubble keeps the PC so the held F/D instruction is traceable.
            dx_instruction_d = NOP;
            dx_a_d           = '0;
            dx_b_d           = '0;
        end
    end

    always_ff @(posedge clock) begin
        dx_instruction_q <= dx_instruction_d;
        dx_pc_q          <= dx_pc_d;
        dx_a_q           <= dx_a_d;
        dx_b_q           <= dx_b_d;
    end

    assign dx_instruction = dx_instruction_q;
    assign dx_PC          = dx_pc_q;
    assign dx_A           = dx_a_q;
    assign dx_B           = dx_b_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected D/X contents are queued when F/D is driven and checked after each edge.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_instruction, fd_PC;
    logic        flush;
    logic [4:0]  ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_readRegA, data_readRegB;
    logic        wb_writeEnable;
    logic [4:0]  wb_ctrl_writeReg;
    logic [31:0] wb_result;
    logic        stall;
    logic [31:0] dx_instruction, dx_PC, dx_A, dx_B;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
    } dx_t;

    dx_t         exp_q[$];
    logic [31:0] rf [32];
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    // Regfile model: combinational read of whatever the stage addresses.
    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    decode_stage dut (
        .clock(clock), .reset(reset),
        .fd_instruction(fd_instruction), .fd_PC(fd_PC), .flush(flush),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .wb_writeEnable(wb_writeEnable), .wb_ctrl_writeReg(wb_ctrl_writeReg), .wb_result(wb_result),
        .stall(stall),
        .dx_instruction(dx_instruction), .dx_PC(dx_PC), .dx_A(dx_A), .dx_B(dx_B)
    );

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 12'd0};
    endfunction

    localparam logic [4:0] ADD = 5'b00000, BNE = 5'b00010, JR = 5'b00100, ADDI = 5'b00101;
    localparam logic [4:0] SW = 5'b00111, LW = 5'b01000, BEX = 5'b10110;

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        dx_t e;
        e.instr = i; e.pc = p; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic step(input string name);
        dx_t got, e;
        @(posedge clock);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, observed dx=%h", name, {dx_instruction, dx_PC, dx_A, dx_B});
        end else begin
            e = exp_q.pop_front();
            got = {dx_instruction, dx_PC, dx_A, dx_B};
            if (got !== e) begin
                bad++;
                $display("FAIL %s: dx instr/pc/a/b got %h %h %h %h want %h %h %h %h",
                         name, got.instr, got.pc, got.a, got.b, e.instr, e.pc, e.a, e.b);
            end
        end
    endtask

    task automatic chk_stall(input string name, input logic want);
        #1;
        total++;
        if (stall !== want) begin
            bad++;
            $display("FAIL %s: stall got %b want %b", name, stall, want);
        end
    endtask

    task automatic chk_addr(input string name, input logic [4:0] wa, input logic [4:0] wb);
        #1;
        total++;
        if ({ctrl_readRegA, ctrl_readRegB} !== {wa, wb}) begin
            bad++;
            $display("FAIL %s: readA/readB got %0d/%0d want %0d/%0d", name, ctrl_readRegA, ctrl_readRegB, wa, wb);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fd_instruction = ins(ADD, 5'd3, 5'd1, 5'd2);
        fd_PC = 32'd4;
        push(32'd0, 32'd0, 32'd0, 32'd0);
        step("reset_c1");
        push(32'd0, 32'd0, 32'd0, 32'd0);
        step("reset_c2");
        chk_stall("reset_stall", 1'b0);
    endtask

    task automatic test_normal();
        reset = 1'b0;
        fd_instruction = ins(ADD, 5'd3, 5'd1, 5'd2);
        fd_PC = 32'd4;
        chk_addr("add_addr", 5'd1, 5'd2);
        push(fd_instruction, 32'd4, 32'd5, 32'd7);
        step("add_issue");
        fd_instruction = ins(BEX, 5'd0, 5'd0, 5'd0);
        chk_addr("bex_addr", 5'd30, 5'd0);
        fd_instruction = ins(BNE, 5'd9, 5'd1, 5'd0);
        chk_addr("bne_addr", 5'd9, 5'd1);
    endtask

    task automatic test_bypass();
        wb_writeEnable = 1'b1; wb_ctrl_writeReg = 5'd2; wb_result = 32'd99;
        fd_instruction = ins(ADD, 5'd3, 5'd1, 5'd2); fd_PC = 32'd8;
        push(fd_instruction, 32'd8, 32'd5, 32'd99);
        step("bypass_b");
        wb_ctrl_writeReg = 5'd1; wb_result = 32'd77;
        fd_PC = 32'd9;
        push(fd_instruction, 32'd9, 32'd77, 32'd7);
        step("bypass_a");
        wb_ctrl_writeReg = 5'd0; wb_result = 32'd99;
        fd_instruction = ins(ADD, 5'd3, 5'd1, 5'd0); fd_PC = 32'd10;
        push(fd_instruction, 32'd10, 32'd5, 32'd0);
        step("bypass_r0");
        wb_writeEnable = 1'b0; wb_ctrl_writeReg = 5'd1;
        fd_instruction = ins(ADD, 5'd3, 5'd1, 5'd2); fd_PC = 32'd11;
        push(fd_instruction, 32'd11, 32'd5, 32'd7);
        step("bypass_off");
    endtask

    task automatic issue_lw(input logic [4:0] rd, input logic [31:0] pc);
        fd_instruction = ins(LW, rd, 5'd1, 5'd0); fd_PC = pc;
        push(fd_instruction, pc, 32'd5, 32'd0);
        step("lw_issue");
    endtask

    task automatic test_load_use();
        issue_lw(5'd4, 32'd12);
        fd_instruction = ins(ADD, 5'd5, 5'd4, 5'd6); fd_PC = 32'd16;
        chk_stall("lu_stall", 1'b1);
        push(32'd0, 32'd16, 32'd0, 32'd0);
        step("lu_bubble");
        chk_stall("lu_clear", 1'b0);
        push(fd_instruction, 32'd16, 32'd40, 32'd60);
        step("lu_reissue");
    endtask

    task automatic test_store_and_r0();
        issue_lw(5'd4, 32'd20);
        fd_instruction = ins(SW, 5'd4, 5'd2, 5'd0); fd_PC = 32'd24;
        chk_stall("sw_stall", 1'b1);
        push(32'd0, 32'd24, 32'd0, 32'd0);
        step("sw_bubble");
        push(fd_instruction, 32'd24, 32'd7, 32'd40);
        step("sw_issue");
        fd_instruction = ins(ADDI, 5'd4, 5'd1, 5'd0); fd_PC = 32'd26;
        chk_stall("addi_rd_not_src", 1'b0);
        push(fd_instruction, 32'd26, 32'd5, 32'd0);
        step("addi_issue");
        issue_lw(5'd0, 32'd28);
        fd_instruction = ins(ADD, 5'd3, 5'd0, 5'd0); fd_PC = 32'd32;
        chk_stall("lw_r0_nostall", 1'b0);
        push(fd_instruction, 32'd32, 32'd0, 32'd0);
        step("r0_issue");
    endtask

    task automatic test_flush_jal();
        issue_lw(5'd4, 32'd36);
        fd_instruction = ins(ADD, 5'd5, 5'd4, 5'd6); fd_PC = 32'd38;
        flush = 1'b1;
        chk_stall("flush_stall", 1'b0);
        push(32'd0, 32'd0, 32'd0, 32'd0);
        step("flush_dx");
        flush = 1'b0;
        wb_writeEnable = 1'b1; wb_ctrl_writeReg = 5'd31; wb_result = 32'd11;
        fd_instruction = ins(JR, 5'd31, 5'd0, 5'd0); fd_PC = 32'd40;
        chk_addr("jr_addr", 5'd31, 5'd0);
        push(fd_instruction, 32'd40, 32'd11, 32'd0);
        step("jr_bypass");
        wb_writeEnable = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue_lw(5'd4, 32'd44);
        fd_instruction = ins(BNE, 5'd4, 5'd2, 5'd0); fd_PC = 32'd48;
        chk_stall("bne_stall", 1'b1);
        reset = 1'b1;
        push(32'd0, 32'd0, 32'd0, 32'd0);
        step("reset_mid_stall");
        reset = 1'b0;
        chk_stall("post_reset_stall", 1'b0);
        push(fd_instruction, 32'd48, 32'd40, 32'd7);
        step("bne_issue");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[0] = 32'd123; rf[1] = 32'd5; rf[2] = 32'd7;
        rf[4] = 32'd40; rf[6] = 32'd60;
        reset = 1'b1; flush = 1'b0;
        fd_instruction = 32'd0; fd_PC = 32'd0;
        wb_writeEnable = 1'b0; wb_ctrl_writeReg = 5'd0; wb_result = 32'd0;
        test_reset();
        test_normal();
        test_bypass();
        test_load_use();
        test_store_and_r0();
        test_flush_jal();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
